// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared defaults for the dual-port-RAM FIFO controller.
// DATA_W/ADDR_W defaults must match the dual_port_ram instance beside the controller.
package dpram_fifo_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W       = 8;
  localparam int unsigned FIFO_ADDR_W       = 6;
  localparam int unsigned FIFO_AFULL_THRESH = 56;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_ptr.sv
// Wrapping ADDR_W-bit pointer with increment enable and synchronous reset.
module fifo_ptr #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + ADDR_W'(1);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM: port A writes, port B reads.
// Owns pointers, occupancy count and registered flags; read data is the RAM's registered q_b.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = FIFO_DATA_W,
  parameter int unsigned ADDR_W       = FIFO_ADDR_W,
  parameter int unsigned AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0] Depth    = (ADDR_W+1)'(fifo_depth(ADDR_W));
  localparam logic [ADDR_W:0] AfullLvl = (ADDR_W+1)'(AFULL_THRESH);

  logic              push, pop;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, afull_q;
  logic              rd_valid_q, overflow_q, underflow_q;

  // Acceptance uses the flags registered at the start of the cycle, so a full FIFO
  // never accepts a push even if a pop frees a slot in the same cycle.
  assign push = wr_en & ~full_q;
  assign pop  = rd_en & ~empty_q;

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == Depth);
      afull_q     <= (count_d >= AfullLvl);
      rd_valid_q  <= pop;
      overflow_q  <= wr_en & full_q;
      underflow_q <= rd_en & empty_q;
    end
  end

  assign ram_data_a  = wr_data;
  assign ram_addr_a  = wr_ptr;
  assign ram_we_a    = push;
  assign ram_data_b  = '0;
  assign ram_addr_b  = rd_ptr;
  assign ram_we_b    = 1'b0;

  assign rd_data     = ram_q_b;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a queue-based FIFO model.
module tb_dpram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int AFULL = 56;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data, ram_data_a, ram_data_b, ram_q_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [AW:0]   count;
  logic          rd_valid, full, empty, almost_full, overflow, underflow, ram_we_a, ram_we_b;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_data_a  (ram_data_a),
    .ram_addr_a  (ram_addr_a),
    .ram_we_a    (ram_we_a),
    .ram_data_b  (ram_data_b),
    .ram_addr_b  (ram_addr_b),
    .ram_we_b    (ram_we_b),
    .ram_q_b     (ram_q_b)
  );

  // Behavioural dual-port RAM: registered read on port B, write on port A.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_b <= mem[ram_addr_b];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, pointers as plain modulo counters.
  logic [DW-1:0] q [$];
  int  m_wp = 0, m_rp = 0;
  bit  m_rd_valid = 0, m_ovf = 0, m_unf = 0, m_started = 0;
  logic [DW-1:0] m_rd_data = '0;
  bit  m_full, m_empty, m_push, m_pop;

  always @(posedge clk) begin
    m_started = 1;
    if (rst) begin
      q.delete();
      m_wp = 0; m_rp = 0;
      m_rd_valid = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      m_push  = wr_en && !m_full;
      m_pop   = rd_en && !m_empty;
      m_ovf   = wr_en && m_full;
      m_unf   = rd_en && m_empty;
      m_rd_valid = m_pop;
      if (m_pop) begin
        m_rd_data = q.pop_front();
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (m_push) begin
        q.push_back(wr_data);
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
  end

  // Per-cycle comparison on the falling edge, against inputs held for this cycle.
  always @(negedge clk) begin
    if (m_started) begin
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      if (m_rd_valid) check("rd_data", 32'(rd_data), 32'(m_rd_data));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      check("ram_we_a", 32'(ram_we_a), 32'(wr_en && q.size() < DEPTH));
      check("ram_addr_a", 32'(ram_addr_a), 32'(m_wp));
      check("ram_data_a", 32'(ram_data_a), 32'(wr_data));
      check("ram_addr_b", 32'(ram_addr_b), 32'(m_rp));
      check("ram_we_b", 32'(ram_we_b), 32'd0);
      check("ram_data_b", 32'(ram_data_b), 32'd0);
    end
  end

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; rst = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick(); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("lit_reset_empty", 32'(empty), 32'd1);
    check("lit_reset_full", 32'(full), 32'd0);
    check("lit_reset_count", 32'(count), 32'd0);
    check("lit_reset_rd_valid", 32'(rd_valid), 32'd0);
    check("lit_reset_we_a", 32'(ram_we_a), 32'd0);

    drive(1'b1, 8'h55, 1'b0, 1'b0);
    #1;
    check("lit_push_we_a", 32'(ram_we_a), 32'd1);
    check("lit_push_addr_a", 32'(ram_addr_a), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("lit_pop_rd_valid", 32'(rd_valid), 32'd1);
    check("lit_pop_rd_data", 32'(rd_data), 32'h55);
    check("lit_pop_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
      if (i == 54) check("lit_afull_55", 32'(almost_full), 32'd0);
      if (i == 55) check("lit_afull_56", 32'(almost_full), 32'd1);
    end
    check("lit_fill_full", 32'(full), 32'd1);
    check("lit_fill_count", 32'(count), 32'd64);

    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    #1;
    check("lit_ovf_we_a", 32'(ram_we_a), 32'd0);
    tick();
    check("lit_ovf_pulse", 32'(overflow), 32'd1);
    check("lit_ovf_count", 32'(count), 32'd64);
    check("lit_ovf_mem", 32'(mem[1]), 32'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("lit_ovf_clear", 32'(overflow), 32'd0);

    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      check("lit_drain_valid", 32'(rd_valid), 32'd1);
      check("lit_drain_data", 32'(rd_data), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check("lit_unf_pulse", 32'(underflow), 32'd1);
    check("lit_unf_no_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 64; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    tick();
    check("lit_fullrw_valid", 32'(rd_valid), 32'd1);
    check("lit_fullrw_data", 32'(rd_data), 32'h00);
    check("lit_fullrw_ovf", 32'(overflow), 32'd1);
    check("lit_fullrw_count", 32'(count), 32'd63);
    for (int i = 0; i < 63; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 8'h88, 1'b1, 1'b0);
    tick();
    check("lit_emptyrw_unf", 32'(underflow), 32'd1);
    check("lit_emptyrw_count", 32'(count), 32'd1);
    check("lit_emptyrw_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
      tick();
    end
    check("lit_pre_rst_count", 32'(count), 32'd10);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check("lit_rst_count", 32'(count), 32'd0);
    check("lit_rst_empty", 32'(empty), 32'd1);
    check("lit_rst_no_valid", 32'(rd_valid), 32'd0);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    #1;
    check("lit_rst_addr_a", 32'(ram_addr_a), 32'd0);
    tick();

    // Randomised phases: push-heavy, pop-heavy, balanced, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      int pw, pr;
      case ((n / 300) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      drive($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr,
            $urandom_range(0, 299) == 0);
      tick();
    end

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
